cache_port_arbiter: RTL and testbench

- Shares the two ports of the preloaded dual-port cache SRAM between NUM_REQ read requesters and one block-fill writer.
- Read requests go to the ports round-robin.
- A fill takes exclusive ownership of port 0 for one block of ELEMENTS_PER_BLOCK words.
- Sits between the PE read interfaces / memory fill path and the SRAM wrapper.

---
 rtl/cache_port_arbiter_pkg.sv | 22 ++
 rtl/cache_port_arbiter_rr_pick2.sv | 43 ++++
 rtl/cache_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and default sizing for the cache port arbiter.
package cache_port_arbiter_pkg;

  localparam int unsigned CPA_WIDTH              = 8;
  localparam int unsigned CPA_DEPTH              = 64;
  localparam int unsigned CPA_LG_DEPTH           = 6;
  localparam int unsigned CPA_ELEMENTS_PER_BLOCK = 4;
  localparam int unsigned CPA_LG_EPB             = 2;
  localparam int unsigned CPA_NUM_REQ            = 4;
  localparam int unsigned CPA_LG_NUM_REQ         = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Width of a block index: address bits left after removing the in-block offset.
  function automatic int unsigned blk_w(input int unsigned depth, input int unsigned epb);
    return $clog2(depth) - $clog2(epb);
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Round-robin scan returning the first two eligible requesters starting at ptr_i.
module cache_port_arbiter_rr_pick2 #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]    elig_i,
  input  logic [LG_NUM_REQ-1:0] ptr_i,
  output logic [LG_NUM_REQ-1:0] first_idx_o,
  output logic                  first_found_o,
  output logic [LG_NUM_REQ-1:0] second_idx_o,
  output logic                  second_found_o
);

  logic [LG_NUM_REQ:0]   sum;
  logic [LG_NUM_REQ-1:0] idx;

  // Walk ptr, ptr+1, ... modulo NUM_REQ and record the first two hits.
  always_comb begin
    first_idx_o    = '0;
    first_found_o  = 1'b0;
    second_idx_o   = '0;
    second_found_o = 1'b0;
    sum            = '0;
    idx            = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (LG_NUM_REQ+1)'(k);
      if (sum >= (LG_NUM_REQ+1)'(NUM_REQ)) begin
        sum = sum - (LG_NUM_REQ+1)'(NUM_REQ);
      end
      idx = sum[LG_NUM_REQ-1:0];
      if (elig_i[idx]) begin
        if (!first_found_o) begin
          first_found_o = 1'b1;
          first_idx_o   = idx;
        end else if (!second_found_o) begin
          second_found_o = 1'b1;
          second_idx_o   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares a dual-port cache SRAM between round-robin readers and a block-fill writer.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH              = CPA_WIDTH,
  parameter int unsigned DEPTH              = CPA_DEPTH,
  parameter int unsigned LG_DEPTH           = CPA_LG_DEPTH,
  parameter int unsigned ELEMENTS_PER_BLOCK = CPA_ELEMENTS_PER_BLOCK,
  parameter int unsigned LG_EPB             = CPA_LG_EPB,
  parameter int unsigned NUM_REQ            = CPA_NUM_REQ,
  parameter int unsigned LG_NUM_REQ         = CPA_LG_NUM_REQ
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LG_DEPTH-1:0]  req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [NUM_REQ*WIDTH-1:0]     resp_data,
  input  logic                         fill_req_valid,
  input  logic [LG_DEPTH-LG_EPB-1:0]   fill_req_block,
  output logic                         fill_req_ready,
  input  logic                         fill_data_valid,
  input  logic [WIDTH-1:0]             fill_data,
  output logic                         fill_data_ready,
  output logic                         fill_done,
  output logic [LG_DEPTH-1:0]          sram_addr_0,
  output logic [LG_DEPTH-1:0]          sram_addr_1,
  output logic [WIDTH-1:0]             sram_din_0,
  output logic [WIDTH-1:0]             sram_din_1,
  output logic                         sram_we_0,
  output logic                         sram_we_1,
  input  logic [WIDTH-1:0]             sram_dout_0,
  input  logic [WIDTH-1:0]             sram_dout_1
);

  localparam int unsigned BLK_W = blk_w(DEPTH, ELEMENTS_PER_BLOCK);

  state_e                state_q, state_d;
  logic [BLK_W-1:0]      block_q, block_d;
  logic [LG_EPB-1:0]     beat_q, beat_d;
  logic [LG_NUM_REQ-1:0] rr_ptr_q, rr_ptr_d;
  logic                  fill_done_q, fill_done_d;
  logic                  tag0_v_q, tag0_v_d, tag1_v_q, tag1_v_d;
  logic [LG_NUM_REQ-1:0] tag0_idx_q, tag0_idx_d, tag1_idx_q, tag1_idx_d;

  logic [LG_DEPTH-1:0]   addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [LG_NUM_REQ-1:0] first_idx, second_idx;
  logic                  first_found, second_found;
  logic                  grant0, grant1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*LG_DEPTH +: LG_DEPTH];
  end

  // A requester targeting the block under fill is held off until the fill ends.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] &&
                !(state_q == ST_FILL && addr_arr[i][LG_DEPTH-1:LG_EPB] == block_q);
    end
  end

  cache_port_arbiter_rr_pick2 #(
    .NUM_REQ    (NUM_REQ),
    .LG_NUM_REQ (LG_NUM_REQ)
  ) u_pick (
    .elig_i         (elig),
    .ptr_i          (rr_ptr_q),
    .first_idx_o    (first_idx),
    .first_found_o  (first_found),
    .second_idx_o   (second_idx),
    .second_found_o (second_found)
  );

  assign grant1 = first_found;
  assign grant0 = second_found && (state_q == ST_IDLE);

  // Fill sequencing, read grants, SRAM port muxing and round-robin pointer advance.
  always_comb begin
    state_d         = state_q;
    block_d         = block_q;
    beat_d          = beat_q;
    rr_ptr_d        = rr_ptr_q;
    fill_done_d     = 1'b0;
    fill_req_ready  = 1'b0;
    fill_data_ready = 1'b0;
    req_ready       = '0;
    tag0_v_d        = 1'b0;
    tag0_idx_d      = second_idx;
    tag1_v_d        = 1'b0;
    tag1_idx_d      = first_idx;
    sram_addr_0     = '0;
    sram_din_0      = '0;
    sram_we_0       = 1'b0;
    sram_addr_1     = '0;

    unique case (state_q)
      ST_IDLE: begin
        fill_req_ready = 1'b1;
        if (fill_req_valid) begin
          state_d = ST_FILL;
          block_d = fill_req_block;
          beat_d  = '0;
        end
      end
      ST_FILL: begin
        fill_data_ready = 1'b1;
        if (fill_data_valid) begin
          sram_we_0   = 1'b1;
          sram_addr_0 = {block_q, beat_q};
          sram_din_0  = fill_data;
          beat_d      = beat_q + LG_EPB'(1);
          if (beat_q == LG_EPB'(ELEMENTS_PER_BLOCK-1)) begin
            state_d     = ST_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
    endcase

    if (grant1) begin
      req_ready[first_idx] = 1'b1;
      sram_addr_1          = addr_arr[first_idx];
      tag1_v_d             = 1'b1;
      rr_ptr_d = (first_idx == LG_NUM_REQ'(NUM_REQ-1)) ? '0 : first_idx + LG_NUM_REQ'(1);
    end
    if (grant0) begin
      req_ready[second_idx] = 1'b1;
      sram_addr_0           = addr_arr[second_idx];
      tag0_v_d              = 1'b1;
      rr_ptr_d = (second_idx == LG_NUM_REQ'(NUM_REQ-1)) ? '0 : second_idx + LG_NUM_REQ'(1);
    end
  end

  assign sram_din_1 = '0;
  assign sram_we_1  = 1'b0;
  assign fill_done  = fill_done_q;

  // Route each port's read data to the requester recorded in its tag.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (tag1_v_q && tag1_idx_q == LG_NUM_REQ'(i)) begin
        resp_valid[i]              = 1'b1;
        resp_data[i*WIDTH +: WIDTH] = sram_dout_1;
      end else if (tag0_v_q && tag0_idx_q == LG_NUM_REQ'(i)) begin
        resp_valid[i]              = 1'b1;
        resp_data[i*WIDTH +: WIDTH] = sram_dout_0;
      end
    end
  end

  // State, fill bookkeeping, pointer and in-flight tag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      block_q     <= '0;
      beat_q      <= '0;
      rr_ptr_q    <= '0;
      fill_done_q <= 1'b0;
      tag0_v_q    <= 1'b0;
      tag0_idx_q  <= '0;
      tag1_v_q    <= 1'b0;
      tag1_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      beat_q      <= beat_d;
      rr_ptr_q    <= rr_ptr_d;
      fill_done_q <= fill_done_d;
      tag0_v_q    <= tag0_v_d;
      tag0_idx_q  <= tag0_idx_d;
      tag1_v_q    <= tag1_v_d;
      tag1_idx_q  <= tag1_idx_d;
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a behavioural dual-port SRAM.
module tb_cache_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [23:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [31:0] resp_data;
  logic        fill_req_valid;
  logic [3:0]  fill_req_block;
  logic        fill_req_ready;
  logic        fill_data_valid;
  logic [7:0]  fill_data;
  logic        fill_data_ready;
  logic        fill_done;
  logic [5:0]  sram_addr_0, sram_addr_1;
  logic [7:0]  sram_din_0, sram_din_1;
  logic        sram_we_0, sram_we_1;
  logic [7:0]  sram_dout_0, sram_dout_1;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt;
  int nbeat;

  cache_port_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .fill_req_valid  (fill_req_valid),
    .fill_req_block  (fill_req_block),
    .fill_req_ready  (fill_req_ready),
    .fill_data_valid (fill_data_valid),
    .fill_data       (fill_data),
    .fill_data_ready (fill_data_ready),
    .fill_done       (fill_done),
    .sram_addr_0     (sram_addr_0),
    .sram_addr_1     (sram_addr_1),
    .sram_din_0      (sram_din_0),
    .sram_din_1      (sram_din_1),
    .sram_we_0       (sram_we_0),
    .sram_we_1       (sram_we_1),
    .sram_dout_0     (sram_dout_0),
    .sram_dout_1     (sram_dout_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM preloaded with mem[a] = 0x37 + a; one-cycle read latency.
  logic [7:0] mem [64];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h37 + 8'(i);
      loaded <= 1'b1;
    end else begin
      if (sram_we_0) mem[sram_addr_0] <= sram_din_0;
      if (sram_we_1) mem[sram_addr_1] <= sram_din_1;
    end
    sram_dout_0 <= mem[sram_addr_0];
    sram_dout_1 <= mem[sram_addr_1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_addr = '0;
    fill_req_valid = 1'b0; fill_req_block = '0; fill_data_valid = 1'b0; fill_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_fill_done", 32'(fill_done), 32'h0);
    chk("rst_fill_req_ready", 32'(fill_req_ready), 32'h1);
    chk("rst_fill_data_ready", 32'(fill_data_ready), 32'h0);
    chk("rst_we0", 32'(sram_we_0), 32'h0);
    chk("rst_addr0", 32'(sram_addr_0), 32'h0);
    chk("rst_addr1", 32'(sram_addr_1), 32'h0);
    chk("rst_din0", 32'(sram_din_0), 32'h0);
    reset_n = 1'b1;
    cyc();

    // single read of address 5
    req_valid = 4'b0001; req_addr[5:0] = 6'd5; #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_addr1", 32'(sram_addr_1), 32'd5);
    chk("single_addr0_idle", 32'(sram_addr_0), 32'h0);
    chk("single_we1", 32'(sram_we_1), 32'h0);
    cyc(); req_valid = '0; #1;
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_resp_data", 32'(resp_data[7:0]), 32'h3C);
    chk("single_resp_others", 32'(resp_data[31:8]), 32'h0);
    cyc(); #1;
    chk("single_resp_drop", 32'(resp_valid), 32'h0);

    // dual grant: requesters 1 (addr 10) and 3 (addr 20)
    req_valid = 4'b1010; req_addr[11:6] = 6'd10; req_addr[23:18] = 6'd20; #1;
    chk("dual_ready", 32'(req_ready), 32'hA);
    chk("dual_addr1", 32'(sram_addr_1), 32'd10);
    chk("dual_addr0", 32'(sram_addr_0), 32'd20);
    cyc(); req_valid = '0; #1;
    chk("dual_resp_valid", 32'(resp_valid), 32'hA);
    chk("dual_resp1", 32'(resp_data[15:8]), 32'h41);
    chk("dual_resp3", 32'(resp_data[31:24]), 32'h4B);
    chk("dual_resp0_zero", 32'(resp_data[7:0]), 32'h0);
    cyc();

    // fairness: all four requesters, addresses 1..4
    req_addr = {6'd4, 6'd3, 6'd2, 6'd1}; req_valid = 4'b1111; #1;
    chk("rr_c0_ready", 32'(req_ready), 32'h3);
    chk("rr_c0_addr1", 32'(sram_addr_1), 32'd1);
    chk("rr_c0_addr0", 32'(sram_addr_0), 32'd2);
    cyc(); #1;
    chk("rr_c1_ready", 32'(req_ready), 32'hC);
    chk("rr_c1_addr1", 32'(sram_addr_1), 32'd3);
    chk("rr_c1_addr0", 32'(sram_addr_0), 32'd4);
    chk("rr_c1_resp_valid", 32'(resp_valid), 32'h3);
    chk("rr_c1_resp0", 32'(resp_data[7:0]), 32'h38);
    chk("rr_c1_resp1", 32'(resp_data[15:8]), 32'h39);
    cyc(); #1;
    chk("rr_c2_ready", 32'(req_ready), 32'h3);
    chk("rr_c2_resp_valid", 32'(resp_valid), 32'hC);
    chk("rr_c2_resp2", 32'(resp_data[23:16]), 32'h3A);
    chk("rr_c2_resp3", 32'(resp_data[31:24]), 32'h3B);
    cyc(); #1;
    chk("rr_c3_ready", 32'(req_ready), 32'hC);
    cyc(); req_valid = '0; #1;
    chk("rr_c4_resp_valid", 32'(resp_valid), 32'hC);
    cyc();

    // fill block 2 while req0 reads addr 9 (stalled) and req1 reads addr 3
    fill_req_valid = 1'b1; fill_req_block = 4'd2; #1;
    chk("fill_req_ready", 32'(fill_req_ready), 32'h1);
    cyc(); fill_req_valid = 1'b0;
    req_addr[5:0] = 6'd9; req_addr[11:6] = 6'd3; req_valid = 4'b0011;
    for (int b = 0; b < 4; b++) begin
      fill_data_valid = 1'b1; fill_data = 8'hA0 + 8'(b); #1;
      chk("fill_req_ready_busy", 32'(fill_req_ready), 32'h0);
      chk("fill_data_ready", 32'(fill_data_ready), 32'h1);
      chk("fill_we0", 32'(sram_we_0), 32'h1);
      chk("fill_addr0", 32'(sram_addr_0), 32'(8 + b));
      chk("fill_din0", 32'(sram_din_0), 32'(8'hA0 + 8'(b)));
      chk("fill_stall_ready", 32'(req_ready), 32'h2);
      chk("fill_addr1", 32'(sram_addr_1), 32'd3);
      chk("fill_no_done", 32'(fill_done), 32'h0);
      if (b > 0) begin
        chk("fill_req1_resp_valid", 32'(resp_valid), 32'h2);
        chk("fill_req1_resp", 32'(resp_data[15:8]), 32'h3A);
      end
      cyc();
    end
    fill_data_valid = 1'b0; #1;
    chk("fill_done_pulse", 32'(fill_done), 32'h1);
    chk("fill_back_idle", 32'(fill_req_ready), 32'h1);
    chk("fill_done_ready", 32'(req_ready), 32'h3);
    chk("fill_done_addr1", 32'(sram_addr_1), 32'd9);
    chk("fill_done_addr0", 32'(sram_addr_0), 32'd3);
    chk("fill_done_we0", 32'(sram_we_0), 32'h0);
    cyc(); req_valid = '0; #1;
    chk("after_fill_resp_valid", 32'(resp_valid), 32'h3);
    chk("after_fill_resp0", 32'(resp_data[7:0]), 32'hA1);
    chk("after_fill_resp1", 32'(resp_data[15:8]), 32'h3A);
    chk("after_fill_done_low", 32'(fill_done), 32'h0);
    cyc();

    // gapped fill of block 5 with beats on alternate cycles
    fill_req_valid = 1'b1; fill_req_block = 4'd5; #1;
    cyc(); fill_req_valid = 1'b0;
    wr_cnt = 0; nbeat = 0;
    for (int c = 0; c < 7; c++) begin
      fill_data_valid = (c % 2 == 0); fill_data = 8'hB0 + 8'(nbeat); #1;
      chk("gap_we0", 32'(sram_we_0), 32'((c % 2) == 0));
      chk("gap_no_done", 32'(fill_done), 32'h0);
      if (sram_we_0) wr_cnt++;
      if (c % 2 == 0) nbeat++;
      cyc();
    end
    fill_data_valid = 1'b0; #1;
    chk("gap_writes", 32'(wr_cnt), 32'd4);
    chk("gap_done_pulse", 32'(fill_done), 32'h1);
    cyc(); #1;
    chk("gap_done_single", 32'(fill_done), 32'h0);
    req_valid = 4'b0100; req_addr[17:12] = 6'd22; #1;
    chk("gap_read_ready", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0; #1;
    chk("gap_read_data", 32'(resp_data[23:16]), 32'hB2);
    cyc();

    // reset in the middle of a fill of block 1 with a read outstanding
    fill_req_valid = 1'b1; fill_req_block = 4'd1; #1;
    cyc(); fill_req_valid = 1'b0;
    fill_data_valid = 1'b1; fill_data = 8'hC0;
    cyc(); fill_data = 8'hC1;
    cyc(); fill_data_valid = 1'b0;
    req_valid = 4'b1000; req_addr[23:18] = 6'd0; #1;
    chk("mid_read_ready", 32'(req_ready), 32'h8);
    cyc();
    reset_n = 1'b0; req_valid = '0; #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_fill_req_ready", 32'(fill_req_ready), 32'h1);
    chk("mid_rst_fill_data_ready", 32'(fill_data_ready), 32'h0);
    chk("mid_rst_no_done", 32'(fill_done), 32'h0);
    cyc(); reset_n = 1'b1; #1;
    chk("post_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("post_rst_no_done", 32'(fill_done), 32'h0);
    chk("post_rst_fill_req_ready", 32'(fill_req_ready), 32'h1);
    cyc(); #1;
    chk("post_rst_no_done2", 32'(fill_done), 32'h0);
    req_addr[5:0] = 6'd5; req_addr[11:6] = 6'd6; req_valid = 4'b0011; #1;
    chk("post_rst_ready", 32'(req_ready), 32'h3);
    chk("post_rst_addr1", 32'(sram_addr_1), 32'd5);
    chk("post_rst_addr0", 32'(sram_addr_0), 32'd6);
    cyc(); req_valid = '0; #1;
    chk("post_rst_resp_valid2", 32'(resp_valid), 32'h3);
    chk("post_rst_kept_word", 32'(resp_data[7:0]), 32'hC1);
    chk("post_rst_unwritten", 32'(resp_data[15:8]), 32'h3D);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
